// File: rtl/demux1x4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer.
//   NUM_CH     : number of output channels
//   SEL_W      : width of the destination select
//   chan_sel_t : destination select type
//   STAT_W     : width of each per-channel push counter
//   sat_inc()  : saturating increment for the push counters
package demux1x4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned STAT_W = 8;

  typedef logic [SEL_W-1:0] chan_sel_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO used for each demux output.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   i_push   : write i_data this cycle (ignored when full)
//   i_data   : word to store
//   o_count  : number of stored words (0..DEPTH)
//   o_full   : o_count == DEPTH
//   o_valid  : channel holds a word
//   i_ready  : consumer takes the head word
//   o_data   : head word (storage at the read pointer, no bypass)
module demux_chan_fifo #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  output logic [CntW-1:0]   o_count,
  output logic              o_full,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Push is gated by full locally so the count can never overshoot DEPTH.
  assign w_push = i_push && !o_full;
  assign w_pop  = o_valid && i_ready;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + 1'b1;
      2'b01:   w_count_d = r_count - 1'b1;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= w_count_d;
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == DepthC);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/demux1x4_stream.sv
// 1-to-4 stream demultiplexer: one producer, four independently buffered consumers.
// Optional push statistics are enabled by defining DEMUX1X4_STATS_EN.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : producer has a word
//   in_ready  : word accepted this cycle (depends only on state and in_sel)
//   in_data   : input word
//   in_sel    : destination channel 0..3
//   out_valid : bit i set when channel i holds a word
//   out_ready : bit i set when consumer i takes its word
//   out_data  : channel i at [i*DATA_W +: DATA_W]
//   stat_clr  : (DEMUX1X4_STATS_EN) synchronous clear of push counters
//   stat_cnt  : (DEMUX1X4_STATS_EN) saturating push count, channel i at [i*8 +: 8]
module demux1x4_stream
  import demux1x4_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  chan_sel_t                in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data
`ifdef DEMUX1X4_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_push;
  logic [CntW-1:0]   w_count [NUM_CH];

  // Only the selected channel's fill level gates acceptance; out_ready never does.
  assign in_ready = !w_full[in_sel];

  always_comb begin
    w_push = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_push[i] = in_valid && in_ready && (in_sel == chan_sel_t'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    demux_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_data  (in_data),
      .o_count (w_count[g]),
      .o_full  (w_full[g]),
      .o_valid (out_valid[g]),
      .i_ready (out_ready[g]),
      .o_data  (out_data[g*DATA_W +: DATA_W])
    );

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
      (w_count[g] <= CntW'(DEPTH)) && (w_full[g] == (w_count[g] == CntW'(DEPTH))));
  end

`ifdef DEMUX1X4_STATS_EN
  logic [STAT_W-1:0] r_stat [NUM_CH];

  // A push coinciding with stat_clr is dropped: the clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_stat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (stat_clr) begin
          r_stat[i] <= '0;
        end else if (w_push[i]) begin
          r_stat[i] <= sat_inc(r_stat[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stat_out
    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat[g];
  end
`endif

endmodule

// File: tb/tb_demux1x4_stream.sv
module tb_demux1x4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
`ifdef DEMUX1X4_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_cnt;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  demux1x4_stream #(
    .DATA_W (4),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX1X4_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt)
`endif
  );

  // Inputs change 1ns after the rising edge; checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid  = 1'($urandom);
      in_data   = 4'($urandom);
      in_sel    = 2'($urandom);
      out_ready = 4'($urandom);
      tick();
    end
    settle();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b want 0000", out_valid);
    end
    n_checks++;
    if (out_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_out_data: got %h want 0000", out_data);
    end
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      settle();
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready sel=%0d: got %b want 1", s, in_ready);
      end
    end
  endtask

  task automatic test_routing();
    logic [3:0] exp_v;
    exp_v = 4'b0000;
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(4'hA + k);
      in_sel   = 2'(k);
      settle();
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL route_in_ready k=%0d: got %b want 1", k, in_ready);
      end
      tick();
      in_valid = 1'b0;
      settle();
      exp_v[k] = 1'b1;
      n_checks++;
      if (out_valid !== exp_v || out_data[k*4 +: 4] !== 4'(4'hA + k)) begin
        n_bad++;
        $display("FAIL route_k%0d: got valid=%b data=%h want valid=%b data=%h",
                 k, out_valid, out_data[k*4 +: 4], exp_v, 4'(4'hA + k));
      end
    end
    n_checks++;
    if (out_data !== 16'hDCBA) begin
      n_bad++;
      $display("FAIL route_all: got %h want dcba", out_data);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL route_drain: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_full_backpressure();
    out_ready = 4'b0000;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    in_data   = 4'h1;
    tick();
    in_data = 4'h2;
    tick();
    in_data = 4'h3;
    settle();
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_full_ready: got %b want 0", in_ready);
    end
    tick();
    out_ready[2] = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 1'b0 || out_data[11:8] !== 4'h1) begin
      n_bad++;
      $display("FAIL bp_head1: got ready=%b data=%h want ready=0 data=1", in_ready,
               out_data[11:8]);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_data[11:8] !== 4'h2) begin
      n_bad++;
      $display("FAIL bp_head2: got ready=%b data=%h want ready=1 data=2", in_ready,
               out_data[11:8]);
    end
    tick();
    in_valid = 1'b0;
    settle();
    n_checks++;
    if (out_valid[2] !== 1'b1 || out_data[11:8] !== 4'h3) begin
      n_bad++;
      $display("FAIL bp_head3: got valid=%b data=%h want valid=1 data=3", out_valid[2],
               out_data[11:8]);
    end
    tick();
    out_ready = 4'b0000;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL bp_empty: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_full_pop();
    out_ready = 4'b0000;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    tick();
    in_data = 4'h6;
    tick();
    in_data      = 4'h7;
    out_ready[1] = 1'b1;
    settle();
    n_checks++;
    if (in_ready !== 1'b0 || out_data[7:4] !== 4'h5) begin
      n_bad++;
      $display("FAIL fp_same_cycle: got ready=%b data=%h want ready=0 data=5", in_ready,
               out_data[7:4]);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_data[7:4] !== 4'h6) begin
      n_bad++;
      $display("FAIL fp_next_cycle: got ready=%b data=%h want ready=1 data=6", in_ready,
               out_data[7:4]);
    end
    tick();
    in_valid = 1'b0;
    settle();
    n_checks++;
    if (out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h7) begin
      n_bad++;
      $display("FAIL fp_order: got valid=%b data=%h want valid=1 data=7", out_valid[1],
               out_data[7:4]);
    end
    tick();
    out_ready = 4'b0000;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL fp_empty: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got [$];
    int         stalls;
    stalls    = 0;
    out_ready = 4'b0000;
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    in_data   = 4'h8;
    tick();
    in_data = 4'h9;
    tick();
    out_ready = 4'b0001;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 4'(k);
      end else begin
        in_valid = 1'b0;
      end
      settle();
      if (k < 16 && in_ready !== 1'b1) stalls++;
      if (out_valid[0] === 1'b1) got.push_back(out_data[3:0]);
      tick();
    end
    n_checks++;
    if (stalls != 0 || got.size() != 16) begin
      n_bad++;
      $display("FAIL b2b_rate: got stalls=%0d words=%0d want stalls=0 words=16", stalls,
               got.size());
    end
    for (int k = 0; k < 16 && k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== 4'(k)) begin
        n_bad++;
        $display("FAIL b2b_word%0d: got %h want %h", k, got[k], 4'(k));
      end
    end
    in_sel = 2'd3;
    settle();
    n_checks++;
    if (out_valid !== 4'b1000 || out_data[15:12] !== 4'h8 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ch3_held: got valid=%b data=%h ready=%b want 1000 8 0", out_valid,
               out_data[15:12], in_ready);
    end
    out_ready = 4'b1000;
    tick();
    n_checks++;
    if (out_data[15:12] !== 4'h9) begin
      n_bad++;
      $display("FAIL b2b_ch3_second: got %h want 9", out_data[15:12]);
    end
    tick();
    out_ready = 4'b0000;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL b2b_empty: got %b want 0000", out_valid);
    end
  endtask

`ifdef DEMUX1X4_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    settle();
    n_checks++;
    if (stat_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL stat_clear0: got %h want 00000000", stat_cnt);
    end
    out_ready = 4'b0001;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_data = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    settle();
    n_checks++;
    if (stat_cnt !== 32'h0000_00FF) begin
      n_bad++;
      $display("FAIL stat_sat: got %h want 000000ff", stat_cnt);
    end
    out_ready = 4'b0000;
    stat_clr  = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = 4'h4;
    tick();
    stat_clr = 1'b0;
    in_sel   = 2'd2;
    tick();
    in_valid = 1'b0;
    settle();
    n_checks++;
    if (stat_cnt !== 32'h0001_0000) begin
      n_bad++;
      $display("FAIL stat_clr_push: got %h want 00010000", stat_cnt);
    end
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
  endtask
`endif

  task automatic test_async_reset();
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 4'hE;
    tick();
    in_sel  = 2'd2;
    in_data = 4'h6;
    tick();
    in_valid = 1'b0;
    settle();
    n_checks++;
    if (out_valid !== 4'b0101) begin
      n_bad++;
      $display("FAIL ar_buffered: got %b want 0101", out_valid);
    end
    rst = 1'b1;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000 || out_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL ar_immediate: got valid=%b data=%h want 0000 0000", out_valid,
               out_data);
    end
    tick();
    rst = 1'b0;
    tick();
    in_sel = 2'd0;
    settle();
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_release: got valid=%b ready=%b want 0000 1", out_valid, in_ready);
    end
`ifdef DEMUX1X4_STATS_EN
    n_checks++;
    if (stat_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL ar_stats: got %h want 00000000", stat_cnt);
    end
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
`ifdef DEMUX1X4_STATS_EN
    stat_clr  = 1'b0;
`endif
    #1;
    test_reset();
    test_routing();
    test_full_backpressure();
    test_full_pop();
    test_back_to_back();
`ifdef DEMUX1X4_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
